pwm_multi_channel: RTL and testbench

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

---
 rtl/pwm_multi_channel.sv | 229 ++++++++++++++++++++++
 tb/tb_pwm_multi_channel.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator with a shared prescaler and a shared 8-bit
// period counter. Each channel compares the counter against its own active
// duty value. Duty values are double buffered: software writes a pending
// value, and the hardware copies it into the active register only at the
// start of a period. Because of this a new duty never produces a partial or
// mixed-width pulse.
//
// Counting modes:
//   edge-aligned   : cnt = 0,1,...,255,0,...         (256 ticks per period)
//   center-aligned : cnt = 0..255 then 254..1, then 0 (510 ticks per period)
//
// Register map (8-bit data, 7-bit address):
//   0x00 en_out[7:0]    0x01 en_out[15:8]
//   0x02 en_pwm[7:0]    0x03 en_pwm[15:8]
//   0x04 prescale (low PRESC_W bits)
//   0x05 mode (bit0: 0 edge-aligned, 1 center-aligned)
//   0x10+i duty_pend[i], for i < NUM_CH
//   A write to any other address, or to a channel index >= NUM_CH, is dropped.
//
// Ports:
//   clk          sole clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   wr_en        register write strobe (one write per cycle)
//   wr_addr      register address
//   wr_data      register write data
//   out          registered channel outputs
//   period_start one-cycle pulse while cnt sits at 0 at the start of a period
// -----------------------------------------------------------------------------
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PRESCALE  = 7'h04;
  localparam logic [6:0] ADDR_MODE      = 7'h05;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

  // Programmable state
  logic [NUM_CH-1:0]  en_out_r;
  logic [NUM_CH-1:0]  en_pwm_r;
  logic [PRESC_W-1:0] prescale_r;
  logic               mode_r;
  logic [7:0]         duty_pend_r [NUM_CH];
  logic [7:0]         duty_act_r  [NUM_CH];

  // Timebase state
  logic [PRESC_W-1:0] pcnt_r;
  logic [7:0]         cnt_r;
  logic               dir_up_r;

  // Combinational helpers
  logic               wr_prescale_s;
  logic               wr_mode_s;
  logic [NUM_CH-1:0]  duty_wr_s;
  logic               tick_s;
  logic [7:0]         cnt_nxt_s;
  logic               dir_nxt_s;
  logic               wrap_s;
  logic               load_s;
  logic [NUM_CH-1:0]  out_nxt_s;

  // Address decode for the registers that have side effects on the timebase
  always_comb begin
    wr_prescale_s = wr_en && (wr_addr == ADDR_PRESCALE);
    wr_mode_s     = wr_en && (wr_addr == ADDR_MODE);
    for (int i = 0; i < NUM_CH; i++) begin
      duty_wr_s[i] = wr_en && (wr_addr == (ADDR_DUTY_BASE + 7'(i)));
    end
  end

  // Prescaler tick: fires on the cycle the divider has counted prescale cycles
  always_comb begin
    tick_s = (pcnt_r == prescale_r);
  end

  // Next value of the period counter and direction on a tick; wrap_s marks
  // the tick that returns cnt to 0, which is the period boundary
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_up_r;
    wrap_s    = 1'b0;
    if (!tick_s) begin
      cnt_nxt_s = cnt_r;
      dir_nxt_s = dir_up_r;
    end else if (!mode_r) begin
      // Edge-aligned: free-running 8-bit wrap
      cnt_nxt_s = cnt_r + 8'd1;
      dir_nxt_s = 1'b1;
      wrap_s    = (cnt_r == 8'hFF);
    end else if (dir_up_r) begin
      // Center-aligned rising half: turn around at the top without repeating 255
      if (cnt_r == 8'hFF) begin
        cnt_nxt_s = 8'hFE;
        dir_nxt_s = 1'b0;
      end else begin
        cnt_nxt_s = cnt_r + 8'd1;
        dir_nxt_s = 1'b1;
      end
    end else begin
      // Center-aligned falling half: stepping 1 -> 0 closes the period
      cnt_nxt_s = cnt_r - 8'd1;
      if (cnt_r == 8'd1) begin
        dir_nxt_s = 1'b1;
        wrap_s    = 1'b1;
      end else begin
        dir_nxt_s = 1'b0;
      end
    end
  end

  // A mode write restarts the counter, so it also cancels a coincident boundary
  always_comb begin
    load_s = tick_s && wrap_s && !wr_mode_s;
  end

  // Per-channel output level from the current counter, duty and enables
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en_out_r[i]) begin
        out_nxt_s[i] = 1'b0;
      end else if (!en_pwm_r[i]) begin
        out_nxt_s[i] = 1'b1;
      end else if (duty_act_r[i] == 8'hFF) begin
        // 0xFF means fully on; a plain compare would drop the cnt=255 slot
        out_nxt_s[i] = 1'b1;
      end else begin
        out_nxt_s[i] = (cnt_r < duty_act_r[i]);
      end
    end
  end

  // Software-visible registers and the double-buffered duty values
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_r   <= {NUM_CH{1'b0}};
      en_pwm_r   <= {NUM_CH{1'b0}};
      prescale_r <= {PRESC_W{1'b0}};
      mode_r     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_pend_r[i] <= 8'h00;
        duty_act_r[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Each enable byte maps to channels 8*k .. 8*k+7; bits for absent
        // channels simply have no flop to land in
        if (wr_en && (wr_addr == ADDR_EN_OUT_LO) && (i < 8)) begin
          en_out_r[i] <= wr_data[i % 8];
        end else if (wr_en && (wr_addr == ADDR_EN_OUT_HI) && (i >= 8)) begin
          en_out_r[i] <= wr_data[i % 8];
        end
        if (wr_en && (wr_addr == ADDR_EN_PWM_LO) && (i < 8)) begin
          en_pwm_r[i] <= wr_data[i % 8];
        end else if (wr_en && (wr_addr == ADDR_EN_PWM_HI) && (i >= 8)) begin
          en_pwm_r[i] <= wr_data[i % 8];
        end
        if (duty_wr_s[i]) begin
          duty_pend_r[i] <= wr_data;
        end
        // A write landing on the boundary cycle goes straight to the active copy
        if (load_s) begin
          duty_act_r[i] <= duty_wr_s[i] ? wr_data : duty_pend_r[i];
        end
      end
      if (wr_prescale_s) begin
        prescale_r <= wr_data[PRESC_W-1:0];
      end
      if (wr_mode_s) begin
        mode_r <= wr_data[0];
      end
    end
  end

  // Prescaler divider; a prescale write restarts it so the new rate begins cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_r <= {PRESC_W{1'b0}};
    end else if (wr_prescale_s || tick_s) begin
      pcnt_r <= {PRESC_W{1'b0}};
    end else begin
      pcnt_r <= pcnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  // Period counter, direction and the period_start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 8'h00;
      dir_up_r     <= 1'b1;
      period_start <= 1'b0;
    end else if (wr_mode_s) begin
      // Silent restart: no period_start for a mode change
      cnt_r        <= 8'h00;
      dir_up_r     <= 1'b1;
      period_start <= 1'b0;
    end else if (tick_s) begin
      cnt_r        <= cnt_nxt_s;
      dir_up_r     <= dir_nxt_s;
      period_start <= wrap_s;
    end else begin
      period_start <= 1'b0;
    end
  end

  // Registered channel outputs, one cycle behind the state that drives them
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= {NUM_CH{1'b0}};
    end else begin
      out <= out_nxt_s;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Drives a 16-channel and a 4-channel instance from the same write bus. A
// behavioural model tracks the position inside the current period as a plain
// integer and derives the counter value arithmetically; a negedge process
// compares both instances against it every cycle. Directed sections pin the
// model with hand-computed widths and spacings, then a randomized section
// mixes writes, mode/prescale changes and resets.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] out16;
  logic        ps16;
  logic [3:0]  out4;
  logic        ps4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  pwm_multi_channel #(.NUM_CH(16), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out(out16), .period_start(ps16)
  );

  pwm_multi_channel #(.NUM_CH(4), .PRESC_W(8)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out(out4), .period_start(ps4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_prescale, m_phase, m_mode, m_pos;
  logic [15:0] m_en_out, m_en_pwm;
  int          m_pend [16];
  int          m_act  [16];
  logic [15:0] exp_out;
  logic        exp_ps;
  int          m_period, m_cnt;
  bit          m_tick, m_wrap, m_mw, m_pw;

  always @(posedge clk) begin
    if (rst) begin
      m_prescale = 0; m_phase = 0; m_mode = 0; m_pos = 0;
      m_en_out = 16'h0; m_en_pwm = 16'h0;
      for (int i = 0; i < 16; i++) begin m_pend[i] = 0; m_act[i] = 0; end
      exp_out = 16'h0; exp_ps = 1'b0;
    end else begin
      m_period = (m_mode != 0) ? 510 : 256;
      m_cnt    = (m_mode == 0) ? m_pos : ((m_pos <= 255) ? m_pos : 510 - m_pos);
      for (int i = 0; i < 16; i++)
        exp_out[i] = m_en_out[i] && (!m_en_pwm[i] || m_act[i] == 255 || m_cnt < m_act[i]);
      m_tick = (m_phase == m_prescale);
      m_wrap = m_tick && (m_pos == m_period - 1);
      m_mw   = wr_en && (wr_addr == 7'h05);
      m_pw   = wr_en && (wr_addr == 7'h04);
      if (wr_en) begin
        case (wr_addr)
          7'h00:   m_en_out[7:0]  = wr_data;
          7'h01:   m_en_out[15:8] = wr_data;
          7'h02:   m_en_pwm[7:0]  = wr_data;
          7'h03:   m_en_pwm[15:8] = wr_data;
          7'h04:   m_prescale     = int'(wr_data);
          7'h05:   m_mode         = int'(wr_data[0]);
          default: if (wr_addr >= 7'h10 && wr_addr < 7'h20)
                     m_pend[int'(wr_addr) - 16] = int'(wr_data);
        endcase
      end
      if (m_mw) begin
        m_pos = 0; exp_ps = 1'b0;
      end else if (m_tick) begin
        m_pos = (m_pos + 1) % m_period; exp_ps = m_wrap;
      end else begin
        exp_ps = 1'b0;
      end
      if (m_wrap && !m_mw)
        for (int i = 0; i < 16; i++) m_act[i] = m_pend[i];
      m_phase = (m_pw || m_tick) ? 0 : m_phase + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("out16", {16'h0, out16}, {16'h0, exp_out});
      check("ps16", {31'h0, ps16}, {31'h0, exp_ps});
      check("out4", {28'h0, out4}, {28'h0, exp_out[3:0]});
      check("ps4", {31'h0, ps4}, {31'h0, exp_ps});
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(input int bound, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!ps16 && gap < bound);
    check("ps_seen", {31'h0, ps16}, 32'd1);
  endtask

  task automatic count_high(input int ch, input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      if (out16[ch]) h++;
    end
  endtask

  int g, h, h1, h2, h3, nz, r, sel;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 7'h0; wr_data = 8'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Held in reset for 1000 cycles with writes presented: all must be ignored
    nz = 0;
    for (int i = 0; i < 1000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 7'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      @(negedge clk);
      if (out16 != 16'h0 || ps16 || out4 != 4'h0) nz++;
    end
    check("rst_idle", nz, 0);
    wr_en = 1'b0; rst = 1'b0;

    // Edge-aligned, prescale 0, duty 0x80 on channel 0
    wr(7'h10, 8'h80); wr(7'h02, 8'h01); wr(7'h00, 8'h01);
    wait_ps(600, g);
    wait_ps(300, g);
    check("edge_gap", g, 256);
    count_high(0, 256, h);
    check("edge_high_ch0", h, 128);

    // Boundary duties on channels 1..3
    wr(7'h11, 8'h00); wr(7'h12, 8'h01); wr(7'h13, 8'hFF);
    wr(7'h02, 8'h0F); wr(7'h00, 8'h0F);
    wait_ps(300, g);
    h1 = 0; h2 = 0; h3 = 0;
    repeat (256) begin
      @(negedge clk);
      if (out16[1]) h1++;
      if (out16[2]) h2++;
      if (out16[3]) h3++;
    end
    check("duty00_high", h1, 0);
    check("duty01_high", h2, 1);
    check("dutyFF_high", h3, 256);

    // Mid-period duty change 0x40 -> 0xC0 on channel 0
    wr(7'h10, 8'h40);
    wait_ps(300, g);
    wait_ps(300, g);
    h = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (out16[0]) h++;
      if (c == 50) begin wr_en = 1'b1; wr_addr = 7'h10; wr_data = 8'hC0; end
      if (c == 51) wr_en = 1'b0;
    end
    check("dbuf_cur_period", h, 64);
    count_high(0, 256, h);
    check("dbuf_next_period", h, 192);

    // Center-aligned with prescale 3: 510 ticks * 4 cycles
    wr(7'h04, 8'd3); wr(7'h05, 8'd1); wr(7'h15, 8'h80);
    wr(7'h02, 8'h2F); wr(7'h00, 8'h2F);
    wait_ps(2100, g);
    wait_ps(2100, g);
    check("center_gap", g, 2040);
    wait_ps(2100, g);

    // Back to edge mode; ignored writes on the 4-channel instance
    wr(7'h04, 8'd0); wr(7'h05, 8'd0);
    wr(7'h14, 8'h55); wr(7'h1F, 8'h99); wr(7'h01, 8'hF0); wr(7'h03, 8'hF0);
    wr(7'h40, 8'hFF); wr(7'h06, 8'hFF);
    wr(7'h00, 8'h00); wr(7'h02, 8'h00);
    @(negedge clk);
    check("en_before", {31'h0, out4[2]}, 32'd0);
    wr(7'h00, 8'h04);
    check("en_lag", {31'h0, out4[2]}, 32'd0);
    @(negedge clk);
    check("en_immediate", {31'h0, out4[2]}, 32'd1);

    // Reset mid-period, then a full period before the first period_start
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out16", {16'h0, out16}, 32'd0);
    check("rst_out4", {28'h0, out4}, 32'd0);
    rst = 1'b0;
    wait_ps(400, g);
    check("rst_gap", g, 256);

    // Randomized traffic
    for (int i = 0; i < 20000; i++) begin
      wr_en = 1'b0; rst = 1'b0;
      r = $urandom_range(0, 999);
      if (r < 60) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0:       wr_addr = 7'($urandom_range(0, 3));
          4:       wr_addr = 7'($urandom_range(6, 15));
          5:       wr_addr = 7'($urandom_range(32, 127));
          default: wr_addr = 7'($urandom_range(16, 31));
        endcase
        wr_data = 8'($urandom);
        wr_en = 1'b1;
      end else if (r == 60) begin
        wr_addr = 7'h04; wr_data = 8'($urandom_range(0, 2)); wr_en = 1'b1;
      end else if (r == 61) begin
        wr_addr = 7'h05; wr_data = 8'($urandom_range(0, 1)); wr_en = 1'b1;
      end else if (r == 62) begin
        rst = 1'b1;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
